// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM/WB-to-write-back bundle plus the write-back results that
// fan out to the register file, the EX-stage HI/LO bypass and the
// decode-stage same-edge bypass.
//   master : MEM/WB side (drives the pipeline fields, observes results)
//   slave  : write-back stage
interface wb_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);

  // Fields from the MEM/WB pipeline register
  logic                        RegWriteIn;
  logic [2:0]                  MemtoReg;
  logic [REG_ADDR_WIDTH-1:0]   WriteRegIn;
  logic [DATA_WIDTH-1:0]       ALUResult;
  logic [DATA_WIDTH-1:0]       ReadData;
  logic [DATA_WIDTH-1:0]       PCPlus4;
  logic [DATA_WIDTH-1:0]       LUIValue;
  logic [2*DATA_WIDTH-1:0]     Product;
  logic [3:0]                  HiLoEnable;
  logic                        MemRead;

  // Register-file write port
  logic                        RegWriteOut;
  logic [REG_ADDR_WIDTH-1:0]   WriteReg;
  logic [DATA_WIDTH-1:0]       WriteData;

  // Architectural HI/LO and their next-edge values
  logic [DATA_WIDTH-1:0]       Hi;
  logic [DATA_WIDTH-1:0]       Lo;
  logic [DATA_WIDTH-1:0]       HiNext;
  logic [DATA_WIDTH-1:0]       LoNext;

  // One-cycle delayed copy of the last register write
  logic                        PrevWriteValid;
  logic [REG_ADDR_WIDTH-1:0]   PrevWriteReg;
  logic [DATA_WIDTH-1:0]       PrevWriteData;

  modport master (
    output RegWriteIn, MemtoReg, WriteRegIn, ALUResult, ReadData, PCPlus4,
           LUIValue, Product, HiLoEnable, MemRead,
    input  RegWriteOut, WriteReg, WriteData, Hi, Lo, HiNext, LoNext,
           PrevWriteValid, PrevWriteReg, PrevWriteData
  );

  modport slave (
    input  RegWriteIn, MemtoReg, WriteRegIn, ALUResult, ReadData, PCPlus4,
           LUIValue, Product, HiLoEnable, MemRead,
    output RegWriteOut, WriteReg, WriteData, Hi, Lo, HiNext, LoNext,
           PrevWriteValid, PrevWriteReg, PrevWriteData
  );

endinterface

// File: rtl/wb_stage.sv
// wb_stage: pipeline write-back stage.
//   - selects register-file write data and suppresses writes to $0
//   - owns the architectural HI/LO registers (mult, mthi, mtlo, madd/msub)
//   - exposes HiNext/LoNext for the EX-stage mfhi/mflo bypass
//   - keeps a one-cycle delayed copy of the last register write so decode
//     can bypass a write landing in the register file on its read edge
// Optional feature macro: WB_HILO_ACC_EN
//   defined   : HiLoEnable codes 2/3 perform 64-bit madd/msub
//   undefined : codes 2/3 are reserved (hold) and no 64-bit adder exists
module wb_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  wb_stage_if.slave  bus
);

  // Write-data select codes carried in MemtoReg; 6 and 7 fall back to ALU
  typedef enum logic [2:0] {
    SEL_ALU  = 3'd0,
    SEL_MEM  = 3'd1,
    SEL_LINK = 3'd2,
    SEL_HI   = 3'd3,
    SEL_LO   = 3'd4,
    SEL_LUI  = 3'd5
  } wb_sel_e;

  // HI/LO operation codes carried in HiLoEnable; 6..15 are reserved (hold)
  typedef enum logic [3:0] {
    HILO_HOLD = 4'd0,
    HILO_MULT = 4'd1,
    HILO_MADD = 4'd2,
    HILO_MSUB = 4'd3,
    HILO_MTHI = 4'd4,
    HILO_MTLO = 4'd5
  } hilo_op_e;

  localparam int ACC_WIDTH = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0]     hi_q;
  logic [DATA_WIDTH-1:0]     lo_q;
  logic [DATA_WIDTH-1:0]     hi_next;
  logic [DATA_WIDTH-1:0]     lo_next;
  logic [DATA_WIDTH-1:0]     write_data;
  logic                      reg_write;
  logic                      prev_valid_q;
  logic [REG_ADDR_WIDTH-1:0] prev_reg_q;
  logic [DATA_WIDTH-1:0]     prev_data_q;

  // A load whose select is not the memory path is a decode error. The write
  // still follows MemtoReg, so the flag only exists as a hook for debug
  // tooling and is intentionally left unconsumed here.
  logic unused_decode_error;
  assign unused_decode_error = bus.MemRead & (bus.MemtoReg != SEL_MEM);

  // ---------------------------------------------------------------------------
  // Register-file write port
  // ---------------------------------------------------------------------------

  // $0 is hard-wired to zero, so a write addressed to it is dropped here
  // rather than relying on the register file to ignore it.
  assign reg_write = bus.RegWriteIn & (bus.WriteRegIn != '0);

  // Write-data mux; HI/LO reads use the registered values, not the bypass
  always_comb begin
    // NOTE: default assignment first so every path drives write_data and no latch is inferred.
    write_data = bus.ALUResult;
    case (bus.MemtoReg)
      SEL_ALU:  write_data = bus.ALUResult;
      SEL_MEM:  write_data = bus.ReadData;
      SEL_LINK: write_data = bus.PCPlus4;
      SEL_HI:   write_data = hi_q;
      SEL_LO:   write_data = lo_q;
      SEL_LUI:  write_data = bus.LUIValue;
      default:  write_data = bus.ALUResult;
    endcase
  end

  // ---------------------------------------------------------------------------
  // HI/LO next state
  // ---------------------------------------------------------------------------

`ifdef WB_HILO_ACC_EN
  // Full-width accumulate so the carry/borrow out of LO ripples into HI;
  // the top carry is dropped, giving modulo 2^(2*DATA_WIDTH) wrap.
  logic [ACC_WIDTH-1:0] acc_sum;
  logic [ACC_WIDTH-1:0] acc_diff;
  assign acc_sum  = {hi_q, lo_q} + bus.Product;
  assign acc_diff = {hi_q, lo_q} - bus.Product;
`endif

  // Decode HiLoEnable into the values HI/LO take at the next edge
  always_comb begin
    hi_next = hi_q;
    lo_next = lo_q;
    case (bus.HiLoEnable)
      HILO_MULT: {hi_next, lo_next} = bus.Product;
`ifdef WB_HILO_ACC_EN
      HILO_MADD: {hi_next, lo_next} = acc_sum;
      HILO_MSUB: {hi_next, lo_next} = acc_diff;
`endif
      HILO_MTHI: hi_next = bus.ALUResult;
      HILO_MTLO: lo_next = bus.ALUResult;
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------

  // HI/LO registers; reset wins over any in-flight mult/madd/msub
  always_ff @(posedge Clk) begin
    // NOTE: every register here is software-visible state, so all of it is cleared on reset.
    if (Reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      hi_q <= hi_next;
      lo_q <= lo_next;
    end
  end

  // Delayed copy of the write retiring this cycle, for the decode bypass
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_valid_q <= 1'b0;
      prev_reg_q   <= '0;
      prev_data_q  <= '0;
    end else begin
      prev_valid_q <= reg_write;
      prev_reg_q   <= bus.WriteRegIn;
      prev_data_q  <= write_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  assign bus.RegWriteOut    = reg_write;
  assign bus.WriteReg       = bus.WriteRegIn;
  assign bus.WriteData      = write_data;
  assign bus.Hi             = hi_q;
  assign bus.Lo             = lo_q;
  assign bus.HiNext         = hi_next;
  assign bus.LoNext         = lo_next;
  assign bus.PrevWriteValid = prev_valid_q;
  assign bus.PrevWriteReg   = prev_reg_q;
  assign bus.PrevWriteData  = prev_data_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: self-checking bench for wb_stage. A vector table covers the
// write-data mux and $0 suppression; hand-written sequences cover HI/LO
// operations, carry/wrap, reset during accumulate and the HI/LO read-back.
// The delayed-write outputs are checked through a scoreboard queue.
module tb_wb_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  wb_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

  wb_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } prev_t;

  prev_t sb[$];

  logic [DW-1:0] exp_hi;
  logic [DW-1:0] exp_lo;

  typedef struct {
    logic          we;
    logic [2:0]    sel;
    logic [AW-1:0] rd;
    logic          mem_read;
    logic [DW-1:0] alu;
    logic          exp_we;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Check next-edge HI/LO, push the expected delayed write, take one edge,
  // then pop and compare the delayed write and the new HI/LO.
  task automatic step(input string tag, input logic v, input logic [AW-1:0] r,
                      input logic [DW-1:0] d, input logic [DW-1:0] nhi,
                      input logic [DW-1:0] nlo);
    prev_t e;
    #1;
    check({tag, " hi_next"}, bus.HiNext, nhi);
    check({tag, " lo_next"}, bus.LoNext, nlo);
    sb.push_back('{v: v, r: r, d: d});
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check({tag, " prev_valid"}, bus.PrevWriteValid, e.v);
    check({tag, " prev_reg"}, bus.PrevWriteReg, e.r);
    check({tag, " prev_data"}, bus.PrevWriteData, e.d);
    exp_hi = nhi;
    exp_lo = nlo;
    check({tag, " hi"}, bus.Hi, exp_hi);
    check({tag, " lo"}, bus.Lo, exp_lo);
  endtask

  task automatic idle_inputs();
    bus.RegWriteIn = 1'b0;
    bus.MemtoReg   = 3'd0;
    bus.WriteRegIn = '0;
    bus.ALUResult  = '0;
    bus.Product    = '0;
    bus.HiLoEnable = 4'd0;
    bus.MemRead    = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 3'd1, 5'd8,  1'b0, 32'hA1A1A1A1, 1'b1, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 3'd0, 5'd0,  1'b0, 32'h00000005, 1'b0, 32'h00000005};
    vecs[2]  = '{1'b1, 3'd0, 5'd31, 1'b0, 32'h11112222, 1'b1, 32'h11112222};
    vecs[3]  = '{1'b1, 3'd2, 5'd31, 1'b0, 32'h11112222, 1'b1, 32'h00400008};
    vecs[4]  = '{1'b1, 3'd3, 5'd3,  1'b0, 32'h00000033, 1'b1, 32'h48484848};
    vecs[5]  = '{1'b1, 3'd4, 5'd4,  1'b0, 32'h00000044, 1'b1, 32'h4C4C4C4C};
    vecs[6]  = '{1'b1, 3'd5, 5'd5,  1'b0, 32'h00000055, 1'b1, 32'h12340000};
    vecs[7]  = '{1'b1, 3'd6, 5'd6,  1'b0, 32'h00000066, 1'b1, 32'h00000066};
    vecs[8]  = '{1'b1, 3'd7, 5'd7,  1'b0, 32'h00000077, 1'b1, 32'h00000077};
    vecs[9]  = '{1'b0, 3'd1, 5'd9,  1'b0, 32'h00000099, 1'b0, 32'hDEADBEEF};
    vecs[10] = '{1'b1, 3'd0, 5'd10, 1'b1, 32'h0000AAAA, 1'b1, 32'h0000AAAA};
    vecs[11] = '{1'b1, 3'd1, 5'd1,  1'b1, 32'h0000BBBB, 1'b1, 32'hDEADBEEF};

    bus.ReadData = 32'hDEADBEEF;
    bus.PCPlus4  = 32'h00400008;
    bus.LUIValue = 32'h12340000;
    idle_inputs();

    // Reset, then one idle cycle
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    check("reset hi", bus.Hi, 32'h0);
    check("reset lo", bus.Lo, 32'h0);
    check("reset prev_valid", bus.PrevWriteValid, 1'b0);
    check("reset prev_reg", bus.PrevWriteReg, 5'd0);
    check("reset prev_data", bus.PrevWriteData, 32'h0);
    exp_hi = '0;
    exp_lo = '0;
    step("idle", 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);

    // Load known HI/LO so mux codes 3/4 read distinct values
    bus.HiLoEnable = 4'd1;
    bus.Product    = {32'h48484848, 32'h4C4C4C4C};
    step("preload", 1'b0, 5'd0, 32'h0, 32'h48484848, 32'h4C4C4C4C);
    idle_inputs();

    // Write-data mux, $0 suppression and load decode-error vectors
    for (int i = 0; i < 12; i++) begin
      bus.RegWriteIn = vecs[i].we;
      bus.MemtoReg   = vecs[i].sel;
      bus.WriteRegIn = vecs[i].rd;
      bus.MemRead    = vecs[i].mem_read;
      bus.ALUResult  = vecs[i].alu;
      #1;
      check($sformatf("vec%0d reg_write", i), bus.RegWriteOut, vecs[i].exp_we);
      check($sformatf("vec%0d write_reg", i), bus.WriteReg, vecs[i].rd);
      check($sformatf("vec%0d write_data", i), bus.WriteData, vecs[i].exp_data);
      step($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].rd, vecs[i].exp_data,
           exp_hi, exp_lo);
    end
    idle_inputs();

    // mult then madd: carry from LO into HI
    bus.HiLoEnable = 4'd1;
    bus.Product    = {32'h00000001, 32'hFFFFFFFF};
    step("mult", 1'b0, 5'd0, 32'h0, 32'h00000001, 32'hFFFFFFFF);
    bus.HiLoEnable = 4'd2;
    bus.Product    = 64'd1;
`ifdef WB_HILO_ACC_EN
    step("madd carry", 1'b0, 5'd0, 32'h0, 32'h00000002, 32'h00000000);
`else
    step("madd rsv", 1'b0, 5'd0, 32'h0, 32'h00000001, 32'hFFFFFFFF);
`endif

    // Reset during madd: accumulation is lost, no delayed write recorded
    bus.HiLoEnable = 4'd2;
    bus.Product    = 64'd5;
    bus.RegWriteIn = 1'b1;
    bus.WriteRegIn = 5'd4;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    check("rst madd hi", bus.Hi, 32'h0);
    check("rst madd lo", bus.Lo, 32'h0);
    check("rst madd prev_valid", bus.PrevWriteValid, 1'b0);
    exp_hi = '0;
    exp_lo = '0;
    idle_inputs();

    // msub from zero wraps to all ones
    bus.HiLoEnable = 4'd3;
    bus.Product    = 64'd1;
`ifdef WB_HILO_ACC_EN
    step("msub wrap", 1'b0, 5'd0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF);
`else
    step("msub rsv", 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
`endif

    // Reserved codes hold
    bus.HiLoEnable = 4'd9;
    bus.Product    = {32'h13579BDF, 32'h2468ACE0};
    bus.ALUResult  = 32'h00005555;
    step("rsv9", 1'b0, 5'd0, 32'h00005555, exp_hi, exp_lo);
    bus.HiLoEnable = 4'd15;
    step("rsv15", 1'b0, 5'd0, 32'h00005555, exp_hi, exp_lo);
    idle_inputs();

    // mthi, then read HI back while a second mthi is in flight
    bus.HiLoEnable = 4'd1;
    bus.Product    = {32'hCAFEF00D, 32'h0BADBEEF};
    step("load a", 1'b0, 5'd0, 32'h0, 32'hCAFEF00D, 32'h0BADBEEF);
    bus.HiLoEnable = 4'd4;
    bus.ALUResult  = 32'h00001234;
    step("mthi", 1'b0, 5'd0, 32'h00001234, 32'h00001234, 32'h0BADBEEF);
    bus.HiLoEnable = 4'd4;
    bus.ALUResult  = 32'h00009999;
    bus.MemtoReg   = 3'd3;
    bus.RegWriteIn = 1'b1;
    bus.WriteRegIn = 5'd2;
    #1;
    check("mfhi reg_write", bus.RegWriteOut, 1'b1);
    check("mfhi write_data", bus.WriteData, 32'h00001234);
    step("mfhi", 1'b1, 5'd2, 32'h00001234, 32'h00009999, 32'h0BADBEEF);
    idle_inputs();

    // mtlo, then read LO back
    bus.HiLoEnable = 4'd1;
    bus.Product    = {32'hCAFEF00D, 32'h0BADBEEF};
    step("load b", 1'b0, 5'd0, 32'h0, 32'hCAFEF00D, 32'h0BADBEEF);
    bus.HiLoEnable = 4'd5;
    bus.ALUResult  = 32'h00001234;
    step("mtlo", 1'b0, 5'd0, 32'h00001234, 32'hCAFEF00D, 32'h00001234);
    bus.HiLoEnable = 4'd0;
    bus.ALUResult  = 32'h0;
    bus.MemtoReg   = 3'd4;
    bus.RegWriteIn = 1'b1;
    bus.WriteRegIn = 5'd2;
    #1;
    check("mflo write_data", bus.WriteData, 32'h00001234);
    step("mflo", 1'b1, 5'd2, 32'h00001234, 32'hCAFEF00D, 32'h00001234);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage directly downstream of the MEM/WB pipeline register.
- Selects the register-file write data, suppresses writes to $0, and owns the architectural HI/LO registers (mult, madd/msub, mthi/mtlo).
- Holds a one-cycle delayed copy of the last register write. The decode stage uses it to bypass writes that land in the register file on the same edge it reads.

Parameters:
- DATA_WIDTH, 32, GPR/HI/LO width; the product input is 2*DATA_WIDTH.
- REG_ADDR_WIDTH, 5, register-file address width.

Ports:
- Clk  in  1  system clock, all state updates on posedge
- Reset  in  1  synchronous, active-high reset
- RegWriteIn  in  1  register write request from MEM/WB
- MemtoReg  in  3  write-data select code from MEM/WB
- WriteRegIn  in  REG_ADDR_WIDTH  destination register (RegDst mux output) from MEM/WB
- ALUResult  in  DATA_WIDTH  ALU result from MEM/WB
- ReadData  in  DATA_WIDTH  data-memory load data from MEM/WB
- PCPlus4  in  DATA_WIDTH  link value from MEM/WB
- LUIValue  in  DATA_WIDTH  pre-shifted LUI immediate from MEM/WB
- Product  in  2*DATA_WIDTH  multiplier result {hi,lo} from MEM/WB
- HiLoEnable  in  4  HI/LO operation code from MEM/WB
- MemRead  in  1  instruction in WB is a load
- RegWriteOut  out  1  register-file write enable
- WriteReg  out  REG_ADDR_WIDTH  register-file write address
- WriteData  out  DATA_WIDTH  register-file write data
- Hi  out  DATA_WIDTH  current HI register
- Lo  out  DATA_WIDTH  current LO register
- HiNext  out  DATA_WIDTH  value HI takes at next edge (EX-stage mfhi bypass)
- LoNext  out  DATA_WIDTH  value LO takes at next edge
- PrevWriteValid  out  1  a register write retired last cycle
- PrevWriteReg  out  REG_ADDR_WIDTH  its address
- PrevWriteData  out  DATA_WIDTH  its data

Behaviour:
- Clocking and reset: single clock Clk; reset Reset is synchronous, active-high. While Reset is high at a posedge: Hi=0, Lo=0, PrevWriteValid=0, PrevWriteReg=0, PrevWriteData=0.
- Combinational outputs (RegWriteOut, WriteReg, WriteData, HiNext, LoNext) follow inputs in the same cycle; zero latency.
- WriteData mux by MemtoReg:
  - 0 ALUResult; 1 ReadData; 2 PCPlus4; 3 Hi; 4 Lo; 5 LUIValue.
  - 6 and 7 are reserved and select ALUResult.
  - Codes 3/4 use the registered Hi/Lo, not HiNext/LoNext.
- RegWriteOut = RegWriteIn AND (WriteRegIn != 0). WriteReg = WriteRegIn always.
- MemRead=1 with MemtoReg!=1 is a decode error: write proceeds using the MemtoReg selection. The behaviour is defined; no assertion is raised.
- HiLoEnable codes, applied at posedge:
  - 0 hold.
  - 1 {Hi,Lo} <= Product.
  - 2 madd: {Hi,Lo} <= {Hi,Lo} + Product.
  - 3 msub: {Hi,Lo} <= {Hi,Lo} - Product.
  - 4 Hi <= ALUResult (mthi), Lo holds.
  - 5 Lo <= ALUResult (mtlo), Hi holds.
  - 6-15 reserved: hold.
- madd/msub arithmetic is 64-bit modulo 2^64. Carry/borrow propagates from Lo into Hi; overflow wraps silently.
- HiNext/LoNext equal the values Hi/Lo will take at the next non-reset edge. They equal Hi/Lo when the code is 0 or reserved.
- Delayed-write register, updated every non-reset posedge:
  - PrevWriteValid <= RegWriteOut.
  - PrevWriteReg <= WriteRegIn.
  - PrevWriteData <= WriteData.
  - Both register write and HI/LO update occur in the same cycle when both are requested; they are independent.
- Reset asserted mid-madd: reset wins; Hi/Lo=0 and the accumulation is lost.

Optional Feature:
- Macro: WB_HILO_ACC_EN.
- Defined: HiLoEnable codes 2 and 3 perform madd/msub as above.
- Undefined: codes 2 and 3 are reserved (Hi/Lo hold, HiNext/LoNext = Hi/Lo), and no 64-bit adder/subtractor is synthesised.

Test Plan:
- Reset high 1 cycle, then idle inputs (HiLoEnable=0, RegWriteIn=0) -> Hi=0, Lo=0, PrevWriteValid=0.
- RegWriteIn=1, WriteRegIn=8, MemtoReg=1, ReadData=0xDEADBEEF -> same cycle RegWriteOut=1, WriteData=0xDEADBEEF. Next cycle PrevWriteValid=1, PrevWriteReg=8, PrevWriteData=0xDEADBEEF.
- RegWriteIn=1, WriteRegIn=0, MemtoReg=0, ALUResult=5 -> RegWriteOut=0. Next cycle PrevWriteValid=0.
- HiLoEnable=1, Product=0x00000001_FFFFFFFF; next cycle HiLoEnable=2 (with WB_HILO_ACC_EN), Product=1 -> Hi=0x00000002, Lo=0x00000000 (carry). Without the macro, Hi=1, Lo=0xFFFFFFFF after the second edge.
- With Hi=0, Lo=0: HiLoEnable=3 (with WB_HILO_ACC_EN), Product=1 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFF (wrap). HiNext/LoNext show 0xFFFFFFFF in the cycle before the edge.
- HiLoEnable=4, ALUResult=0x1234, then next cycle MemtoReg=3, RegWriteIn=1, WriteRegIn=2 -> WriteData=0x1234, Lo unchanged. Same sequence with HiLoEnable=5 and MemtoReg=4 -> WriteData=0x1234, Hi unchanged.
